// File: rtl/clk_enable_scheduler.sv
// Four-channel programmable clock-enable generator with glitch-free retargeting.
// Ports: clk, rst, cfg_valid/cfg_ready/cfg_ch/cfg_div/cfg_done, tick, clk_out, active.
module clk_enable_scheduler #(
  parameter int          W    = 26,
  parameter int unsigned DIV0 = 37500000,
  parameter int unsigned DIV1 = 3,
  parameter int unsigned DIV2 = 0,
  parameter int unsigned DIV3 = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [1:0]   cfg_ch,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_done,
  output logic [3:0]   tick,
  output logic [3:0]   clk_out,
  output logic [3:0]   active
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t       state;
  logic [1:0]   ch_p;
  logic [W-1:0] div_p;
  logic [W-1:0] cnt_r [4];
  logic [W-1:0] div_r [4];
  logic [W-1:0] div_rst [4];
  logic [3:0]   wrap;
  logic         apply;

  assign div_rst[0] = W'(DIV0);
  assign div_rst[1] = W'(DIV1);
  assign div_rst[2] = W'(DIV2);
  assign div_rst[3] = W'(DIV3);

  assign cfg_ready = (state == IDLE);

  // wrap marks the period boundary of an enabled channel
  always_comb begin
    wrap   = '0;
    active = '0;
    for (int i = 0; i < 4; i++) begin
      active[i] = (div_r[i] != '0);
      wrap[i]   = active[i] && (cnt_r[i] == div_r[i] - W'(1));
    end
  end

  // an off channel has no boundary to wait for
  always_comb begin
    apply = 1'b0;
    if (state == PENDING)
      apply = (div_r[ch_p] == '0) || wrap[ch_p];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ch_p     <= '0;
      div_p    <= '0;
      cfg_done <= 1'b0;
      tick     <= '0;
      clk_out  <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= '0;
        div_r[i] <= div_rst[i];
      end
    end else begin
      cfg_done <= apply;
      unique case (state)
        IDLE: begin
          if (cfg_valid) begin
            ch_p  <= cfg_ch;
            div_p <= cfg_div;
            state <= PENDING;
          end
        end
        PENDING: begin
          if (apply)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      for (int i = 0; i < 4; i++) begin
        if (div_r[i] == '0) begin
          cnt_r[i]   <= '0;
          tick[i]    <= 1'b0;
          clk_out[i] <= 1'b0;
        end else if (wrap[i]) begin
          cnt_r[i]   <= '0;
          tick[i]    <= 1'b1;
          clk_out[i] <= ~clk_out[i];
        end else begin
          cnt_r[i]   <= cnt_r[i] + W'(1);
          tick[i]    <= 1'b0;
        end
        if (apply && (ch_p == 2'(i))) begin
          div_r[i] <= div_p;
          cnt_r[i] <= '0;
          // disabling wins over the boundary tick/toggle
          if (div_p == '0) begin
            tick[i]    <= 1'b0;
            clk_out[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Self-checking bench for clk_enable_scheduler.
// Scoreboard of per-cycle expected outputs plus scenario checks.
module tb_clk_enable_scheduler;

  localparam int W  = 26;
  localparam int D0 = 7;
  localparam int D1 = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic [1:0]   cfg_ch = '0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready;
  logic         cfg_done;
  logic [3:0]   tick;
  logic [3:0]   clk_out;
  logic [3:0]   active;

  clk_enable_scheduler #(
    .W(W), .DIV0(D0), .DIV1(D1), .DIV2(0), .DIV3(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_done(cfg_done),
    .tick(tick),
    .clk_out(clk_out),
    .active(active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q [$];
  logic [13:0] e;
  logic [13:0] obs;
  assign obs = {cfg_ready, cfg_done, active, clk_out, tick};

  // reference model of the behaviour, one expected vector per clock edge
  logic [W-1:0] m_cnt [4];
  logic [W-1:0] m_div [4];
  logic [W-1:0] n_cnt [4];
  logic [W-1:0] n_div [4];
  logic [3:0]   m_clko, n_clko, n_tick, n_act;
  logic         m_pend, n_pend, n_app;
  logic [1:0]   m_ch, n_ch;
  logic [W-1:0] m_dp, n_dp;

  always_comb begin
    n_app  = m_pend && (m_div[m_ch] == '0 ||
                        m_cnt[m_ch] == m_div[m_ch] - W'(1));
    n_pend = m_pend;
    n_ch   = m_ch;
    n_dp   = m_dp;
    n_tick = '0;
    n_clko = m_clko;
    n_act  = '0;
    for (int i = 0; i < 4; i++) begin
      n_div[i] = m_div[i];
      n_cnt[i] = m_cnt[i] + W'(1);
      if (m_div[i] == '0) begin
        n_cnt[i]  = '0;
        n_clko[i] = 1'b0;
      end else if (m_cnt[i] == m_div[i] - W'(1)) begin
        n_cnt[i]  = '0;
        n_tick[i] = 1'b1;
        n_clko[i] = ~m_clko[i];
      end
      if (n_app && m_ch == 2'(i)) begin
        n_div[i] = m_dp;
        n_cnt[i] = '0;
        if (m_dp == '0) begin
          n_tick[i] = 1'b0;
          n_clko[i] = 1'b0;
        end
      end
      n_act[i] = (n_div[i] != '0);
    end
    if (m_pend) n_pend = !n_app;
    else if (cfg_valid) begin
      n_pend = 1'b1;
      n_ch   = cfg_ch;
      n_dp   = cfg_div;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_div[0] <= W'(D0);
      m_div[1] <= W'(D1);
      m_div[2] <= '0;
      m_div[3] <= '0;
      for (int i = 0; i < 4; i++) m_cnt[i] <= '0;
      m_clko <= '0;
      m_pend <= 1'b0;
      m_ch   <= '0;
      m_dp   <= '0;
      exp_q.delete();
    end else begin
      m_cnt  <= n_cnt;
      m_div  <= n_div;
      m_clko <= n_clko;
      m_pend <= n_pend;
      m_ch   <= n_ch;
      m_dp   <= n_dp;
      exp_q.push_back({!n_pend, n_app, n_act, n_clko, n_tick});
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== {1'b1, 1'b0, 4'b0011, 4'b0000, 4'b0000}) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", obs, 14'b10001100000000);
    end
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty: obs %b", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++; $display("FAIL sb_reset: got %b want %b", obs, e);
        end
      end
      checks++;
      if (tick[1] !== (k % 3 == 0)) begin
        errors++; $display("FAIL tick1_div3 k=%0d: got %b", k, tick[1]);
      end
      checks++;
      if (clk_out[1] !== ((k / 3) % 2 == 1)) begin
        errors++; $display("FAIL clko1_div3 k=%0d: got %b", k, clk_out[1]);
      end
    end
    checks++;
    if (clk_out[0] !== 1'b1) begin
      errors++; $display("FAIL clko0_pre_reset: got %b want 1", clk_out[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tick !== 4'b0 || clk_out !== 4'b0 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: tick %b clk_out %b done %b want 0",
               tick, clk_out, cfg_done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_enable_off();
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = W'(4);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL sb_empty: obs %b", obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++; $display("FAIL sb_en_acc: got %b want %b", obs, e);
      end
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL en_ready_drop: got %b want 0", cfg_ready);
    end
    cfg_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL sb_empty: obs %b", obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++; $display("FAIL sb_en_app: got %b want %b", obs, e);
      end
    end
    checks++;
    if (cfg_ready !== 1'b1 || cfg_done !== 1'b1 || active[2] !== 1'b1) begin
      errors++;
      $display("FAIL en_done: ready %b done %b active2 %b want 1 1 1",
               cfg_ready, cfg_done, active[2]);
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty: obs %b", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++; $display("FAIL sb_en_run: got %b want %b", obs, e);
        end
      end
      checks++;
      if (tick[2] !== (k % 4 == 0) || cfg_done !== 1'b0) begin
        errors++;
        $display("FAIL tick2_first k=%0d: tick2 %b done %b", k, tick[2], cfg_done);
      end
    end
  endtask

  task automatic test_retarget();
    int cyc = 0;
    int last = -1;
    int ready_lo = 0;
    int dones = 0;
    int gaps5 = 0;
    bit seen_done = 1'b0;
    for (int n = 0; n < 6 && last < 0; n++) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty: obs %b", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++; $display("FAIL sb_rt_find: got %b want %b", obs, e);
        end
      end
      if (tick[1]) last = cyc;
    end
    checks++;
    if (last < 0) begin
      errors++; $display("FAIL rt_find_tick: got none want tick1 within 6");
    end
    for (int n = 0; n < 22; n++) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty: obs %b", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++; $display("FAIL sb_rt: got %b want %b", obs, e);
        end
      end
      // present the request so it is accepted on the cnt=2 -> 0 edge
      if (n == 1) begin
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = W'(5);
      end else begin
        cfg_valid = 1'b0;
      end
      if (n < 2) continue;
      if (!cfg_ready) ready_lo++;
      if (cfg_done) begin
        dones++;
        checks++;
        if (tick[1] !== 1'b1) begin
          errors++; $display("FAIL rt_apply_tick: got %b want 1", tick[1]);
        end
      end
      if (tick[1]) begin
        checks++;
        if ((cyc - last) != (seen_done ? 5 : 3)) begin
          errors++;
          $display("FAIL rt_gap: got %0d want %0d", cyc - last, seen_done ? 5 : 3);
        end
        if (seen_done) gaps5++;
        last = cyc;
      end
      if (cfg_done) seen_done = 1'b1;
    end
    checks++;
    if (ready_lo != 3 || dones != 1 || gaps5 < 2) begin
      errors++;
      $display("FAIL rt_summary: ready_lo %0d dones %0d gaps5 %0d want 3 1 >=2",
               ready_lo, dones, gaps5);
    end
  endtask

  task automatic test_pending_ignore();
    int dones = 0;
    bit got = 1'b0;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = W'(4);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty: obs %b", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++; $display("FAIL sb_pend: got %b want %b", obs, e);
        end
      end
      if (k == 1) begin
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = W'(2);
      end else begin
        cfg_valid = 1'b0;
      end
      if (cfg_done) dones++;
    end
    checks++;
    if (dones != 1 || active[3] !== 1'b0) begin
      errors++;
      $display("FAIL pend_ignore: dones %0d active3 %b want 1 0", dones, active[3]);
    end
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = W'(D0);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL sb_empty: obs %b", obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++; $display("FAIL sb_pend_new: got %b want %b", obs, e);
      end
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL pend_new_accept: ready %b want 0", cfg_ready);
    end
    cfg_valid = 1'b0;
    for (int k = 0; k < 9 && !got; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty: obs %b", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++; $display("FAIL sb_pend_wait: got %b want %b", obs, e);
        end
      end
      if (cfg_done) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL pend_new_done: got timeout want cfg_done");
    end
  endtask

  task automatic test_disable();
    bit got = 1'b0;
    int t2 = 0;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = '0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty: obs %b", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++; $display("FAIL sb_dis_wait: got %b want %b", obs, e);
        end
      end
      cfg_valid = 1'b0;
      if (cfg_done) got = 1'b1;
    end
    checks++;
    if (!got || tick[1] !== 1'b0 || clk_out[1] !== 1'b0 || active[1] !== 1'b0) begin
      errors++;
      $display("FAIL dis_apply: done %b tick1 %b clko1 %b act1 %b want 1 0 0 0",
               got, tick[1], clk_out[1], active[1]);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty: obs %b", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++; $display("FAIL sb_dis_run: got %b want %b", obs, e);
        end
      end
      checks++;
      if (tick[1] !== 1'b0 || clk_out[1] !== 1'b0) begin
        errors++; $display("FAIL dis_off: tick1 %b clko1 %b want 0 0", tick[1], clk_out[1]);
      end
      if (tick[2]) t2++;
    end
    checks++;
    if (t2 != 2) begin
      errors++; $display("FAIL dis_ch2_rate: got %0d ticks want 2", t2);
    end
  endtask

  task automatic test_div_one();
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = W'(1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty: obs %b", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++; $display("FAIL sb_one_cfg: got %b want %b", obs, e);
        end
      end
      cfg_valid = 1'b0;
    end
    checks++;
    if (cfg_done !== 1'b1 || tick[3] !== 1'b0 || active[3] !== 1'b1) begin
      errors++;
      $display("FAIL one_apply: done %b tick3 %b act3 %b want 1 0 1",
               cfg_done, tick[3], active[3]);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty: obs %b", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++; $display("FAIL sb_one_run: got %b want %b", obs, e);
        end
      end
      checks++;
      if (tick[3] !== 1'b1 || clk_out[3] !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL one_run k=%0d: tick3 %b clko3 %b", k, tick[3], clk_out[3]);
      end
    end
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = W'(5);
    @(negedge clk);
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL sb_empty: obs %b", obs);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        errors++; $display("FAIL sb_one_pend: got %b want %b", obs, e);
      end
    end
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL one_pend_ready: got %b want 0", cfg_ready);
    end
    cfg_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tick !== 4'b0 || clk_out !== 4'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL pend_reset: tick %b clk_out %b ready %b want 0 0 1",
               tick, clk_out, cfg_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (active !== 4'b0011) begin
      errors++; $display("FAIL reset_divs: active %b want 0011", active);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_empty: obs %b", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          errors++; $display("FAIL sb_lost: got %b want %b", obs, e);
        end
      end
      checks++;
      if (cfg_done !== 1'b0 || tick[3] !== 1'b0 || active[3] !== 1'b0) begin
        errors++;
        $display("FAIL update_lost: done %b tick3 %b act3 %b want 0 0 0",
                 cfg_done, tick[3], active[3]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable_off();
    test_retarget();
    test_pending_ignore();
    test_disable();
    test_div_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_enable_scheduler.md
Name: clk_enable_scheduler

Overview:
- Four-channel programmable clock-enable generator for the VGA subsystem.
- Replaces free-running fixed dividers with runtime-reconfigurable channels, e.g. pixel tick, blink rate, animation step and debounce sample.
- Each channel produces a one-cycle tick and a square wave; a single config port retargets any channel's divisor.
- Divisor changes are glitch-free: they take effect only on that channel's period boundary.

Parameters:
- W, 26, width of divisor and counter registers.
- DIV0, 37500000, channel 0 reset divisor (period in clk cycles; 0 = channel off).
- DIV1, 3, channel 1 reset divisor.
- DIV2, 0, channel 2 reset divisor.
- DIV3, 0, channel 3 reset divisor.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  block can accept config.
- cfg_ch  in  2  target channel.
- cfg_div  in  W  new divisor; 0 disables channel.
- cfg_done  out  1  one-cycle pulse when the pending divisor is applied.
- tick  out  4  per-channel one-cycle enable pulses.
- clk_out  out  4  per-channel square waves, period 2*div.
- active  out  4  per-channel: div != 0.

Behaviour:
- Reset (async, immediate):
  - cnt[i]=0, div[i]=DIVi, tick=0, clk_out=0, cfg_done=0.
  - FSM=IDLE, cfg_ready=1.
  - active reflects reset divisors.
  - Reset during PENDING discards the update.
- Channel i with div[i]=D>0, per clk edge:
  - If cnt[i]==D-1: cnt[i]<=0, tick[i]<=1, clk_out[i]<=~clk_out[i].
  - Else: cnt[i]<=cnt[i]+1, tick[i]<=0.
  - Tick period is exactly D cycles; clk_out period is 2D.
  - D=1: tick held high continuously; clk_out toggles every cycle.
- Channel with div=0: cnt held 0, tick=0, clk_out forced 0.
- All outputs are registered; no combinational path from inputs to outputs except cfg_ready (a function of FSM only).
- FSM IDLE:
  - cfg_ready=1.
  - On edge with cfg_valid=1: latch ch_p<=cfg_ch and div_p<=cfg_div, go to PENDING.
- FSM PENDING:
  - cfg_ready=0; cfg_valid is ignored (no queueing).
  - Apply condition: div[ch_p]==0 (apply on the first PENDING edge), or cnt[ch_p]==div[ch_p]-1 (period boundary).
  - On the apply edge: div[ch_p]<=div_p, cnt[ch_p]<=0, cfg_done<=1, go to IDLE.
  - If the old D>0, that edge still produces the normal tick/toggle.
  - If div_p==0, clk_out[ch_p]<=0 and tick[ch_p]<=0 override the toggle on that edge.
  - If the old D==0 and div_p>0, the first tick occurs div_p edges after the apply edge.
- Latency:
  - Accept edge to apply edge is 1 edge if the target is off.
  - Otherwise it is up to old D edges.
  - cfg_done is visible the cycle after the apply edge.
- Reconfiguring with the same divisor is legal: the boundary is waited for, the counter phase is unchanged and cfg_done pulses.
- Non-target channels are never disturbed by configuration.
- Counter width: divisors up to 2^W-1 are supported; no wrap beyond D-1.

Test Plan:
- Reset, DIV1=3, run 12 cycles:
  - tick[1] high on cycles 3,6,9,12.
  - clk_out[1] toggles on those edges.
  - Outputs 0 while rst=1.
  - Asserting rst mid-count zeroes cnt, tick and clk_out immediately.
- Channel 2 off, write cfg_ch=2 cfg_div=4:
  - cfg_ready drops 1 cycle; cfg_done pulses the next cycle.
  - tick[2] first at 4 edges after apply, then every 4.
  - active[2]=1.
- Channel 1 at D=3, write cfg_div=5 when cnt[1]=0:
  - Apply coincides with the tick at cnt=2.
  - Next ticks are spaced 5.
  - No tick spacing other than 3 or 5 ever observed.
  - cfg_ready=0 for 3 cycles.
- While PENDING, pulse cfg_valid with a different channel:
  - Ignored; only the first request is applied.
  - After cfg_done, a new request is accepted.
- Write cfg_div=0 to channel 1:
  - At the boundary, tick[1] stays 0, clk_out[1]=0, active[1]=0.
  - Channels 0, 2 and 3 timing is unchanged.
- Write cfg_div=1 to channel 3:
  - tick[3] constant 1 from 1 edge after apply.
  - clk_out[3] toggles every cycle.
  - Assert rst during a pending update: update lost, div[3] returns to DIV3.
